// File: rtl/gb80_fetch_unit.sv
// gb80_fetch_unit
// ---------------
// Instruction prefetch stage sitting directly in front of the gb80
// instruction register and decoder. It owns the program counter, issues
// single-byte reads on the memory bus and queues the returned bytes, each
// tagged with its address, in a small FIFO. The decoder pops bytes through
// a valid/ready handshake. A redirect (jump, call, return, interrupt)
// flushes the queue and restarts fetching at a new address.
//
// Parameters
//   DEPTH         prefetch FIFO entries (power of two, >= 2)
//   RESET_VECTOR  PC value loaded on reset
//
// Ports
//   i_clk            system clock, rising-edge
//   i_reset          asynchronous active-low reset
//   i_redirect       one-cycle pulse: flush FIFO, PC <= i_redirect_addr
//   i_redirect_addr  new fetch address
//   o_mem_rd_req     read request, held until i_mem_ack
//   o_mem_addr       read address, stable while o_mem_rd_req is high
//   i_mem_data       read data, valid when i_mem_ack is high
//   i_mem_ack        request accepted and data returned this cycle
//   o_instr_valid    FIFO non-empty
//   o_instr_data     byte at the FIFO head
//   o_instr_pc       address of the byte at the FIFO head
//   i_instr_ready    decoder consumes the head byte this cycle
//   o_fifo_count     current FIFO occupancy

module gb80_fetch_unit #(
  parameter int          DEPTH        = 4,
  parameter logic [15:0] RESET_VECTOR = 16'h0100
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_redirect,
  input  logic [15:0]              i_redirect_addr,
  output logic                     o_mem_rd_req,
  output logic [15:0]              o_mem_addr,
  input  logic [7:0]               i_mem_data,
  input  logic                     i_mem_ack,
  output logic                     o_instr_valid,
  output logic [7:0]               o_instr_data,
  output logic [15:0]              o_instr_pc,
  input  logic                     i_instr_ready,
  output logic [$clog2(DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          r_state;
  logic [15:0]     r_pc;
  logic            r_req;
  logic [15:0]     r_addr;
  logic [CW-1:0]   r_count;
  logic            r_valid;
  logic [15:0]     r_entPc   [DEPTH];
  logic [7:0]      r_entData [DEPTH];

  logic            w_pop;
  logic            w_push;
  logic [CW-1:0]   w_nextCount;
  logic            w_space;
  logic [AW-1:0]   w_wrIdx;

  // Handshake decode for this cycle. A redirect suppresses the push so the
  // byte returned alongside it is dropped; the FIFO clear in the storage
  // block takes care of overriding any pop. w_space answers whether there
  // is room for one more byte once this cycle's push/pop have landed, which
  // is what lets the FSM keep a request going without ever overfilling.
  always_comb begin
    w_pop       = r_valid & i_instr_ready;
    w_push      = (r_state == REQ) & i_mem_ack & ~i_redirect;
    w_nextCount = r_count + CW'(w_push) - CW'(w_pop);
    w_space     = (w_nextCount < CW'(DEPTH));
    w_wrIdx     = AW'(r_count - CW'(w_pop));
  end

  // Prefetch queue kept as a shift register so the head always lives in
  // entry 0 and can drive the outputs straight from a flop. On a pop every
  // entry moves down one slot; a simultaneous push lands in the slot just
  // behind the last surviving entry, which is why the write index already
  // accounts for the pop.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entPc[i]   <= '0;
        r_entData[i] <= '0;
      end
    end else if (i_redirect) begin
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_count <= w_nextCount;
      r_valid <= (w_nextCount != '0);
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          r_entPc[i]   <= r_entPc[i+1];
          r_entData[i] <= r_entData[i+1];
        end
      end
      if (w_push) begin
        r_entPc[w_wrIdx]   <= r_pc;
        r_entData[w_wrIdx] <= i_mem_data;
      end
    end
  end

  // Fetch sequencer. REQ keeps a request on the bus back to back while the
  // queue has room, giving one byte per cycle from zero-wait memory. When a
  // redirect catches a request in flight without its ack, DISCARD keeps the
  // old request on the bus until the memory answers, then throws the byte
  // away. A redirect that lands in the same cycle as that ack finishes the
  // old transaction, so it goes straight to IDLE rather than waiting for an
  // ack that will never come.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_VECTOR;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_redirect) begin
            r_pc <= i_redirect_addr;
          end else if (w_space) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end

        REQ: begin
          if (i_redirect) begin
            r_pc <= i_redirect_addr;
            if (i_mem_ack) begin
              r_state <= IDLE;
              r_req   <= 1'b0;
            end else begin
              r_state <= DISCARD;
            end
          end else if (i_mem_ack) begin
            r_pc <= r_pc + 16'd1;
            if (w_space) begin
              r_addr <= r_pc + 16'd1;
            end else begin
              r_state <= IDLE;
              r_req   <= 1'b0;
            end
          end
        end

        DISCARD: begin
          if (i_redirect) begin
            r_pc <= i_redirect_addr;
          end
          if (i_mem_ack) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_rd_req  = r_req;
  assign o_mem_addr    = r_addr;
  assign o_instr_valid = r_valid;
  assign o_instr_data  = r_entData[0];
  assign o_instr_pc    = r_entPc[0];
  assign o_fifo_count  = r_count;

endmodule

// File: doc/gb80_fetch_unit.md
Name: gb80_fetch_unit

Overview:
Instruction prefetch stage directly upstream of the gb80 instruction register and decoder. It owns the program counter and issues byte reads to the memory bus. Returned opcode and operand bytes go into a small FIFO, and the decoder pops them through a valid/ready handshake. A redirect input (jump, call, return, interrupt) flushes the queue and restarts fetching at a new address.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
RESET_VECTOR, 16'h0100, PC value loaded on reset.

Ports:
i_clk  input  1  system clock; all state changes on the rising edge.
i_reset  input  1  asynchronous, active-low reset.
i_redirect  input  1  one-cycle pulse: flush the FIFO and load the PC from i_redirect_addr.
i_redirect_addr  input  16  new fetch address.
o_mem_rd_req  output  1  memory read request; held high until acknowledged.
o_mem_addr  output  16  read address; stable while o_mem_rd_req is high.
i_mem_data  input  8  read data; valid only in a cycle where i_mem_ack is high.
i_mem_ack  input  1  request accepted and data returned in the same cycle.
o_instr_valid  output  1  FIFO is non-empty.
o_instr_data  output  8  byte at the FIFO head.
o_instr_pc  output  16  address of the byte at the FIFO head.
i_instr_ready  input  1  decoder consumes the head byte this cycle when o_instr_valid is also high.
o_fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
Reset (i_reset low, asynchronous):
- PC = RESET_VECTOR; state = IDLE.
- FIFO is empty and o_fifo_count = 0.
- o_mem_rd_req = 0, o_mem_addr = 0.
- o_instr_valid = 0, o_instr_data = 0, o_instr_pc = 0.
- Reset mid-transaction abandons the request immediately; the bus must tolerate a dropped request.

All control outputs are registered. o_instr_data and o_instr_pc are the registered head entry, and are meaningful only while o_instr_valid is high.

Each FIFO entry stores {pc[15:0], data[7:0]}.
- Push happens on i_mem_ack in state REQ.
- Pop happens when o_instr_valid and i_instr_ready are both high.
- Push and pop in the same cycle leave the count unchanged.
- Pop while empty is ignored.
- A push never happens while full; the FSM guarantees this.

Let space = (count + push - pop) < DEPTH, evaluated on the current cycle's events.

State machine:
- IDLE
  - With no redirect and space true: next state REQ, o_mem_rd_req <= 1, o_mem_addr <= PC.
- REQ (request outstanding; o_mem_addr = PC)
  - On i_mem_ack: push {PC, i_mem_data}, then PC <= PC + 1.
  - If space still holds after the push: stay in REQ with o_mem_addr <= PC + 1. This back-to-back path gives one byte per cycle from zero-wait memory.
  - Otherwise: go to IDLE and drop o_mem_rd_req.
- DISCARD (redirect arrived while a request was outstanding)
  - Hold the request and the old address until i_mem_ack, then drop the returned data.
  - Next state is IDLE; the request is reissued from the new PC.

Redirect:
- Takes priority over push and pop in the same cycle.
- FIFO is cleared and PC <= i_redirect_addr.
- From IDLE: stay in IDLE; the new request goes out on the following cycle.
- From REQ without i_mem_ack in the same cycle: go to DISCARD.
- From REQ with i_mem_ack in the same cycle: the returned byte is dropped and the next state is IDLE.
- In DISCARD: PC is reloaded and the state stays DISCARD.

Latency:
- First request is visible 1 cycle after reset release.
- A byte acked at edge N makes o_instr_valid high after edge N.
- Redirect to the first new byte is 3 cycles with zero-wait memory: IDLE, then REQ+ack, then valid.

Address arithmetic:
- PC is 16-bit modulo; 16'hFFFF increments to 16'h0000.

Test Plan:
- Zero-wait memory returning addr[7:0] as data, decoder ready always high, after reset: requests at 0100, 0101, 0102 and so on, one per cycle. Decoder sees data 00, 01, 02 and so on with o_instr_pc matching.
- Decoder ready held low with DEPTH=4: exactly 4 acks, then o_mem_rd_req drops and o_fifo_count = 4. Raise ready for 1 cycle: one pop, then one new request at 0104.
- Ack delayed 3 cycles: o_mem_rd_req and o_mem_addr = 0100 stay stable for 3 cycles. Only one push occurs.
- Redirect to 1234 while a request for 0102 is pending and the FIFO holds 2: FIFO empties the next cycle. The late ack for 0102 is dropped. The next request is for 1234 and the first valid byte has o_instr_pc = 1234.
- Redirect to FFFE with zero-wait memory: fetched addresses are FFFE, FFFF, 0000, 0001 (wrap).
- Reset asserted low mid-REQ: all outputs go to 0 immediately without a clock. After release, the first request is for 0100.
